reg_cycle_arb: RTL

REG_CYCLE_ARB -- requirements
Module: reg_cycle_arb

---
 rtl/reg_cycle_arb.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/reg_cycle_arb.sv
// Bus-cycle arbiter: internal register acks, WD33C93 CPU accesses and
// WD33C93 DMA byte transfers share one strobe sequencer; all outputs registered.
module reg_cycle_arb #(
  parameter int STROBE_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic AS_,
  input  logic RW,
  input  logic REG_HIT,
  input  logic WDREGREQ,
  input  logic DREQ_,
  input  logic DMA_EN,
  input  logic DMADIR,
  output logic DSACK0_,
  output logic DSACK1_,
  output logic REG_LE,
  output logic SCSI_CS_,
  output logic IOR_,
  output logic IOW_,
  output logic DACK_,
  output logic DMA_XFER,
  output logic BUSY
);

  typedef enum logic [3:0] {
    IDLE,
    REG_ACK,
    WD_SETUP,
    WD_STROBE,
    WD_HOLD,
    CPU_ACK,
    DMA_SETUP,
    DMA_STROBE,
    DMA_HOLD
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

  state_t     state_q, state_d;
  logic       pri_dma_q, pri_dma_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic       dir_q, dir_d;

  logic dsack0_q, dsack0_d;
  logic dsack1_q, dsack1_d;
  logic reg_le_q, reg_le_d;
  logic cs_q, cs_d;
  logic ior_q, ior_d;
  logic iow_q, iow_d;
  logic dack_q, dack_d;
  logic xfer_q, xfer_d;
  logic busy_q, busy_d;

  logic cpu_reg, cpu_wd, dma_rq;
  logic strobe_rd;

  assign cpu_reg = !AS_ & REG_HIT;
  assign cpu_wd  = !AS_ & WDREGREQ & !REG_HIT;
  assign dma_rq  = !DREQ_ & DMA_EN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      pri_dma_q <= 1'b0;
      cnt_q     <= 4'd0;
      rw_q      <= 1'b0;
      dir_q     <= 1'b0;
      dsack0_q  <= 1'b1;
      dsack1_q  <= 1'b1;
      reg_le_q  <= 1'b0;
      cs_q      <= 1'b1;
      ior_q     <= 1'b1;
      iow_q     <= 1'b1;
      dack_q    <= 1'b1;
      xfer_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pri_dma_q <= pri_dma_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      dir_q     <= dir_d;
      dsack0_q  <= dsack0_d;
      dsack1_q  <= dsack1_d;
      reg_le_q  <= reg_le_d;
      cs_q      <= cs_d;
      ior_q     <= ior_d;
      iow_q     <= iow_d;
      dack_q    <= dack_d;
      xfer_q    <= xfer_d;
      busy_q    <= busy_d;
    end
  end

  // Outputs are decoded from the next state so they appear in the first
  // cycle of each state while still coming straight from flops.
  always_comb begin
    state_d   = state_q;
    pri_dma_d = pri_dma_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    dir_d     = dir_q;
    reg_le_d  = 1'b0;
    dsack0_d  = 1'b1;
    dsack1_d  = 1'b1;
    cs_d      = 1'b1;
    ior_d     = 1'b1;
    iow_d     = 1'b1;
    dack_d    = 1'b1;
    xfer_d    = 1'b0;
    busy_d    = 1'b0;
    strobe_rd = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_reg) begin
          state_d  = REG_ACK;
          reg_le_d = !RW;
        end else if (cpu_wd && (!dma_rq || !pri_dma_q)) begin
          state_d   = WD_SETUP;
          rw_d      = RW;
          pri_dma_d = 1'b1;
        end else if (dma_rq) begin
          state_d   = DMA_SETUP;
          dir_d     = DMADIR;
          pri_dma_d = 1'b0;
        end
      end
      REG_ACK: if (AS_) state_d = IDLE;
      WD_SETUP: begin
        state_d = WD_STROBE;
        cnt_d   = CNT_LOAD;
      end
      WD_STROBE: begin
        if (cnt_q == 4'd0) state_d = WD_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      // A CPU that already dropped AS_ gets no ack; the strobe still finished.
      WD_HOLD: state_d = AS_ ? IDLE : CPU_ACK;
      CPU_ACK: if (AS_) state_d = IDLE;
      DMA_SETUP: begin
        state_d = DMA_STROBE;
        cnt_d   = CNT_LOAD;
      end
      DMA_STROBE: begin
        if (cnt_q == 4'd0) state_d = DMA_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DMA_HOLD: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    case (state_d)
      REG_ACK: begin
        dsack0_d = 1'b0;
        dsack1_d = 1'b0;
      end
      WD_SETUP, WD_HOLD: cs_d = 1'b0;
      WD_STROBE: begin
        cs_d      = 1'b0;
        strobe_rd = rw_d;
        ior_d     = !strobe_rd;
        iow_d     = strobe_rd;
      end
      CPU_ACK: dsack0_d = 1'b0;
      DMA_SETUP: dack_d = 1'b0;
      DMA_STROBE: begin
        dack_d    = 1'b0;
        strobe_rd = dir_d;
        ior_d     = !strobe_rd;
        iow_d     = strobe_rd;
      end
      DMA_HOLD: begin
        dack_d = 1'b0;
        xfer_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign DSACK0_  = dsack0_q;
  assign DSACK1_  = dsack1_q;
  assign REG_LE   = reg_le_q;
  assign SCSI_CS_ = cs_q;
  assign IOR_     = ior_q;
  assign IOW_     = iow_q;
  assign DACK_    = dack_q;
  assign DMA_XFER = xfer_q;
  assign BUSY     = busy_q;

endmodule
